// File: rtl/dmem_arb_pkg.sv
// Shared types and default sizes for the data-memory arbiter.
package dmem_arb_pkg;

  localparam int unsigned ADDR_W_DEF   = 10;
  localparam int unsigned DATA_W_DEF   = 32;
  localparam int unsigned MAX_LOCK_DEF = 16;

  // ARB: normal round-robin, LOCKED: debug owns the port, FORCE: one core slot.
  typedef enum logic [1:0] {
    ARB    = 2'd0,
    LOCKED = 2'd1,
    FORCE  = 2'd2
  } arb_state_e;

  typedef enum logic {
    PORT_CORE = 1'b0,
    PORT_DBG  = 1'b1
  } port_e;

endpackage

// File: rtl/dmem_arbiter_if.sv
// Bus bundle around the arbiter: core port, debug port and the dmem port.
// The slave view belongs to the arbiter. The master view belongs to the
// environment that drives requests and supplies memory read data.
interface dmem_arbiter_if
  import dmem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF
) ();

  // Core load/store unit
  logic              core_req;
  logic              core_we;
  logic [ADDR_W-1:0] core_addr;
  logic [DATA_W-1:0] core_wdata;
  logic              core_gnt;
  logic              core_stall;
  logic              core_rvalid;
  logic [DATA_W-1:0] core_rdata;

  // Debug/loader master
  logic              dbg_req;
  logic              dbg_we;
  logic [ADDR_W-1:0] dbg_addr;
  logic [DATA_W-1:0] dbg_wdata;
  logic              dbg_lock;
  logic              dbg_gnt;
  logic              dbg_rvalid;
  logic [DATA_W-1:0] dbg_rdata;

  // Data memory
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  core_req, core_we, core_addr, core_wdata,
    output core_gnt, core_stall, core_rvalid, core_rdata,
    input  dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_lock,
    output dbg_gnt, dbg_rvalid, dbg_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output core_req, core_we, core_addr, core_wdata,
    input  core_gnt, core_stall, core_rvalid, core_rdata,
    output dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_lock,
    input  dbg_gnt, dbg_rvalid, dbg_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata
  );

endinterface

// File: rtl/dmem_arb_lock_timer.sv
// Saturating count of cycles the debug master has held the lock.
// The expired output asserts in the cycle whose count update reaches
// MAX_LOCK. The arbiter can then schedule the forced core slot for the
// very next cycle.
module dmem_arb_lock_timer
  import dmem_arb_pkg::*;
#(
  parameter int unsigned MAX_LOCK = MAX_LOCK_DEF
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,    // restart count; with en the restart value is 1
  input  logic en,       // count this cycle
  output logic expired
);

  localparam int unsigned CNT_W = $clog2(MAX_LOCK + 1);

  logic [CNT_W-1:0] lock_cnt_q, lock_cnt_d;

  // Next count: clear has priority, then a saturating increment.
  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    lock_cnt_d = lock_cnt_q;
    if (clear) begin
      lock_cnt_d = en ? CNT_W'(1) : '0;
    end else if (en && (lock_cnt_q != CNT_W'(MAX_LOCK))) begin
      lock_cnt_d = lock_cnt_q + CNT_W'(1);
    end
  end

  assign expired = en && (lock_cnt_d == CNT_W'(MAX_LOCK));

  // Count register.
  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lock_cnt_q <= '0;
    end else begin
      lock_cnt_q <= lock_cnt_d;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single dmem port between the core LSU and the debug/loader master.
// Grants are combinational and same-cycle, so at most one access reaches
// memory per cycle. Read data comes back one cycle after its grant and is
// steered by a registered tag.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W   = ADDR_W_DEF,
  parameter int unsigned DATA_W   = DATA_W_DEF,
  parameter int unsigned MAX_LOCK = MAX_LOCK_DEF
) (
  input  logic           clk,
  input  logic           reset_n,
  dmem_arbiter_if.slave  bus
);

  arb_state_e state_q, state_d;
  port_e      last_gnt_q, last_gnt_d;
  logic       rd_pend_q, rd_pend_d;
  port_e      rd_tag_q, rd_tag_d;

  logic core_gnt, dbg_gnt;
  logic tmr_clear, tmr_en, lock_expired;

  logic              mem_en_c, mem_we_c;
  logic [ADDR_W-1:0] mem_addr_c;
  logic [DATA_W-1:0] mem_wdata_c;

  // Grant decision for the current state. Grants are forced low while reset
  // is asserted so no strobe can reach memory during reset.
  always_comb begin
    core_gnt = 1'b0;
    dbg_gnt  = 1'b0;
    if (reset_n) begin
      case (state_q)
        ARB: begin
          core_gnt = bus.core_req && (!bus.dbg_req || (last_gnt_q == PORT_DBG));
          dbg_gnt  = bus.dbg_req && (!bus.core_req || (last_gnt_q == PORT_CORE));
        end
        LOCKED:  dbg_gnt  = bus.dbg_req;
        FORCE:   core_gnt = bus.core_req;
        default: ;
      endcase
    end
  end

  // Lock timer control: restarts outside LOCKED and counts every LOCKED cycle.
  always_comb begin
    tmr_clear = 1'b0;
    tmr_en    = 1'b0;
    case (state_q)
      ARB: begin
        tmr_clear = 1'b1;
        tmr_en    = dbg_gnt && bus.dbg_lock;
      end
      LOCKED:  tmr_en    = 1'b1;
      FORCE:   tmr_clear = 1'b1;
      default: tmr_clear = 1'b1;
    endcase
  end

  dmem_arb_lock_timer #(
    .MAX_LOCK (MAX_LOCK)
  ) u_lock_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (tmr_clear),
    .en      (tmr_en),
    .expired (lock_expired)
  );

  // FSM next state. Releasing the lock takes priority over the forced core slot.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ARB: begin
        if (dbg_gnt && bus.dbg_lock) state_d = LOCKED;
      end
      LOCKED: begin
        if (!bus.dbg_lock)                      state_d = ARB;
        else if (lock_expired && bus.core_req)  state_d = FORCE;
      end
      FORCE:   state_d = bus.dbg_lock ? LOCKED : ARB;
      default: state_d = ARB;
    endcase
  end

  // Round-robin pointer and read-response tag. Both change only on a real grant.
  always_comb begin
    last_gnt_d = last_gnt_q;
    if (core_gnt)      last_gnt_d = PORT_CORE;
    else if (dbg_gnt)  last_gnt_d = PORT_DBG;

    rd_pend_d = (core_gnt && !bus.core_we) || (dbg_gnt && !bus.dbg_we);
    rd_tag_d  = rd_tag_q;
    if (rd_pend_d) rd_tag_d = dbg_gnt ? PORT_DBG : PORT_CORE;
  end

  // Memory port mux: driven from the granted requester, all zero when idle.
  always_comb begin
    mem_en_c    = 1'b0;
    mem_we_c    = 1'b0;
    mem_addr_c  = '0;
    mem_wdata_c = '0;
    if (core_gnt) begin
      mem_en_c    = 1'b1;
      mem_we_c    = bus.core_we;
      mem_addr_c  = bus.core_addr;
      mem_wdata_c = bus.core_wdata;
    end else if (dbg_gnt) begin
      mem_en_c    = 1'b1;
      mem_we_c    = bus.dbg_we;
      mem_addr_c  = bus.dbg_addr;
      mem_wdata_c = bus.dbg_wdata;
    end
  end

  // State registers. Reset makes the core win the first tie and drops any pending read.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ARB;
      last_gnt_q <= PORT_DBG;
      rd_pend_q  <= 1'b0;
      rd_tag_q   <= PORT_CORE;
    end else begin
      state_q    <= state_d;
      last_gnt_q <= last_gnt_d;
      rd_pend_q  <= rd_pend_d;
      rd_tag_q   <= rd_tag_d;
    end
  end

  assign bus.core_gnt    = core_gnt;
  assign bus.dbg_gnt     = dbg_gnt;
  assign bus.core_stall  = bus.core_req && !core_gnt && reset_n;

  assign bus.mem_en      = mem_en_c;
  assign bus.mem_we      = mem_we_c;
  assign bus.mem_addr    = mem_addr_c;
  assign bus.mem_wdata   = mem_wdata_c;

  assign bus.core_rvalid = rd_pend_q && (rd_tag_q == PORT_CORE);
  assign bus.dbg_rvalid  = rd_pend_q && (rd_tag_q == PORT_DBG);
  assign bus.core_rdata  = bus.core_rvalid ? bus.mem_rdata : '0;
  assign bus.dbg_rdata   = bus.dbg_rvalid  ? bus.mem_rdata : '0;

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Shares the single data-memory port of the single-cycle RISC-V core between the core's load/store unit and a debug/loader master (program/data preload, post-run memory dump). Sits between the core datapath and `dmem`. Grants at most one access per cycle, stalls the core when it loses arbitration, and returns read data one cycle after grant. A debug lock allows atomic multi-access bursts, bounded by a timeout so the core cannot starve.

## Interface
- `ADDR_W`, 10, word-address width of data memory
- `DATA_W`, 32, data width
- `MAX_LOCK`, 16, max consecutive cycles debug may hold the lock before one forced core slot

- `clk`  in  1  system clock
- `reset_n`  in  1  asynchronous, active-low reset
- `core_req`  in  1  core access request (load or store)
- `core_we`  in  1  1 = store, 0 = load
- `core_addr`  in  ADDR_W  core word address
- `core_wdata`  in  DATA_W  core store data
- `core_gnt`  out  1  core access accepted this cycle (combinational)
- `core_stall`  out  1  `core_req & ~core_gnt`; holds PC/pipeline
- `core_rvalid`  out  1  core read data valid (registered)
- `core_rdata`  out  DATA_W  core read data
- `dbg_req`, `dbg_we`, `dbg_addr`, `dbg_wdata`, `dbg_gnt`, `dbg_rvalid`, `dbg_rdata`: same as core equivalents, debug port
- `dbg_lock`  in  1  debug requests exclusive ownership while high
- `mem_en`  out  1  memory access strobe
- `mem_we`  out  1  memory write enable
- `mem_addr`  out  ADDR_W  memory address
- `mem_wdata`  out  DATA_W  memory write data
- `mem_rdata`  in  DATA_W  memory read data, valid cycle after `mem_en & ~mem_we`

## Operation
- States: ARB, LOCKED, FORCE.
- ARB: only one requester -> grant it. Both -> round-robin on `last_gnt` (grant the port not granted last). Grant debug with `dbg_lock`=1 -> LOCKED, `lock_cnt`=1.
- LOCKED: only debug can be granted; `core_gnt`=0. `lock_cnt` increments every cycle. `dbg_lock`=0 -> ARB. `lock_cnt`==MAX_LOCK with `core_req`=1 -> FORCE. `lock_cnt` saturates at MAX_LOCK with no core request.
- FORCE: one cycle; core granted if requesting, debug blocked; then LOCKED if `dbg_lock` still high with `lock_cnt`=0, else ARB. FORCE with `core_req`=0 still consumes the slot.
- `mem_*` driven combinationally from the granted port; `mem_en`=0 and `mem_addr`/`mem_wdata`/`mem_we`=0 when no grant.
- Read response: registered `rd_pend` and `rd_tag` capture grant of a load; next cycle the tagged port gets `rvalid`=1 and `rdata`=`mem_rdata`; the other port's `rdata`=0.
- Stores produce no `rvalid`.
- `last_gnt` updates only on an actual grant.

## Timing
- Grant: 0 cycles (same cycle as `req`). Read data: 1 cycle after grant. Write: committed at clock edge of grant cycle.
- Throughput: one access per cycle; back-to-back loads from different ports return in order.
- Reset (async, `reset_n`=0): state=ARB, `last_gnt`=debug (core wins first tie), `lock_cnt`=0, `rd_pend`=0, `rd_tag`=core; all `gnt`/`rvalid`/`stall`/`mem_*` outputs 0, `rdata`=0.
- Reset mid-read: pending `rvalid` is dropped; no response after release.
- Requester dropping `req` without grant: no side effect; request is not queued.
- `dbg_lock`=1 with `dbg_req`=0 in ARB: no lock taken.

## Structure
- Package `dmem_arb_pkg`: `arb_state_e` {ARB, LOCKED, FORCE}, `port_e` {PORT_CORE=0, PORT_DBG=1}, default widths.
- Sub-module `dmem_arb_lock_timer`: saturating `lock_cnt`, clear/enable inputs, `expired` output at MAX_LOCK.
- Top: FSM, round-robin pointer, grant mux, read tag register.

## Test plan
- Core alone: load addr 0x004 after store 0xDEADBEEF -> `core_gnt`=1 same cycle, `core_rvalid`=1 next cycle with `core_rdata`=0xDEADBEEF, `core_stall`=0 throughout.
- Both request continuously after reset -> grants alternate core, debug, core, debug; `core_stall`=1 only on debug cycles.
- Debug lock, MAX_LOCK=4, core requesting -> 4 debug grants, 1 forced core grant, then debug again; `core_stall` high 4 of every 5 cycles.
- Back-to-back loads core@0x010 (0x11111111) then debug@0x020 (0x22222222) -> `core_rvalid` then `dbg_rvalid` on consecutive cycles, correct data, other port's `rdata`=0.
- `reset_n` asserted in cycle after a granted load -> no `rvalid` on any port, all outputs 0, first tie after release goes to core.
- Debug store 0xCAFEF00D @0x3FF then core load @0x3FF -> core reads 0xCAFEF00D; address wrap-free at top of ADDR_W range.
